// File: rtl/ms_enc_sched.sv
`default_nettype none
// ============================================================================
// Module   : ms_enc_sched
// Purpose  : Job sequencer for the range-encoder datapath. On a start pulse it
//            walks i_size symbols out of the symbol BRAM, hands each to the
//            encoder over a valid/ready handshake, issues a single flush
//            request, and writes every byte the encoder emits into the output
//            BRAM. The job ends with a one-cycle o_done and a byte count.
//
// Ports    : i_clk / i_rst       clock, asynchronous active-high reset
//            i_start / i_size    job start pulse (IDLE only) and symbol count
//            o_busy / o_done     job in progress / end-of-job pulse
//            o_byte_cnt          bytes written in the current or last job
//            o_overflow          sticky: a byte arrived with output BRAM full
//            o_sym_re/addr,
//            i_sym_data          symbol BRAM read port (1-cycle latency)
//            o_enc_valid/data,
//            i_enc_ready         symbol handshake towards the encoder
//            o_enc_flush         one-cycle flush request
//            i_byte_vld/i_byte   byte emitted by the encoder
//            i_enc_finish        encoder flush complete
//            o_out_we/addr/data  output BRAM write port (registered)
//            o_err               sticky watchdog error
//
// Options  : `define MS_SCHED_WDT_EN adds an inactivity watchdog on the
//            ISSUE/DRAIN waits (limit WDT_CYCLES) and an ERR exit state.
//            Without it o_err is tied low and those waits are unbounded.
//
// Revision : 1.0 - initial release
// ============================================================================
module ms_enc_sched #(
  parameter int SYM_AW     = 16,
  parameter int OUT_AW     = 16,
  parameter int WDT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [31:0]       i_size,
  output logic              o_busy,
  output logic              o_done,
  output logic [OUT_AW:0]   o_byte_cnt,
  output logic              o_overflow,
  output logic              o_sym_re,
  output logic [SYM_AW-1:0] o_sym_addr,
  input  logic [7:0]        i_sym_data,
  output logic              o_enc_valid,
  output logic [7:0]        o_enc_data,
  input  logic              i_enc_ready,
  output logic              o_enc_flush,
  input  logic              i_byte_vld,
  input  logic [7:0]        i_byte,
  input  logic              i_enc_finish,
  output logic              o_out_we,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic [7:0]        o_out_data,
  output logic              o_err
);

  // Largest job size / output capacity, both one bit wider than the address.
  localparam logic [SYM_AW:0] c_sym_max = {1'b1, {SYM_AW{1'b0}}};
  localparam logic [31:0]     c_size_lim = 32'(c_sym_max);
  localparam logic [SYM_AW:0] c_idx_one  = {{SYM_AW{1'b0}}, 1'b1};
  localparam logic [OUT_AW:0] c_out_full = {1'b1, {OUT_AW{1'b0}}};
  localparam logic [OUT_AW:0] c_cnt_one  = {{OUT_AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_ISSUE   = 3'd3,
    S_FLUSH   = 3'd4,
    S_DRAIN   = 3'd5,
`ifdef MS_SCHED_WDT_EN
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
`else
    S_DONE    = 3'd6
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [SYM_AW:0]   r_size;
  logic [SYM_AW:0]   r_idx;
  logic [SYM_AW:0]   w_idx_inc;
  logic [SYM_AW:0]   w_size_clamped;
  logic [7:0]        r_enc_data;

  logic [OUT_AW:0]   r_byte_cnt;
  logic              r_overflow;
  logic              r_out_we;
  logic [OUT_AW-1:0] r_out_addr;
  logic [7:0]        r_out_data;

  logic              w_start_acc;
  logic              w_handshake;
  logic              w_capture_en;
  logic              w_in_err;

  // Oversized requests are clamped so the index can never wrap past the
  // end of the symbol BRAM.
  assign w_size_clamped = (i_size > c_size_lim) ? c_sym_max : i_size[SYM_AW:0];
  assign w_start_acc    = (r_state == S_IDLE) && i_start;
  assign w_handshake    = o_enc_valid && i_enc_ready;
  assign w_idx_inc      = r_idx + c_idx_one;

  // --------------------------------------------------------------------------
  // Optional inactivity watchdog
  // --------------------------------------------------------------------------
`ifdef MS_SCHED_WDT_EN
  localparam int               c_wdt_w    = $clog2(WDT_CYCLES + 1);
  localparam logic [c_wdt_w-1:0] c_wdt_last = c_wdt_w'(WDT_CYCLES - 1);
  localparam logic [c_wdt_w-1:0] c_wdt_one  = c_wdt_w'(1);

  logic [c_wdt_w-1:0] r_wdt;
  logic               r_err;
  logic               w_wdt_activity;
  logic               w_wdt_armed;
  logic               w_wdt_expired;

  assign w_wdt_activity = w_handshake || i_byte_vld || i_enc_finish;
  assign w_wdt_armed    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  // Fires on the last idle cycle of the window so ERR is entered exactly
  // WDT_CYCLES cycles after the wait began or after the last activity.
  assign w_wdt_expired  = w_wdt_armed && !w_wdt_activity && (r_wdt == c_wdt_last);
  assign w_in_err       = (r_state == S_ERR);
  assign o_err          = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdt <= '0;
    end else if (!w_wdt_armed || w_wdt_activity) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + c_wdt_one;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_next_state == S_ERR) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt = (WDT_CYCLES != 0);
  assign w_in_err     = 1'b0;
  assign o_err        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = (w_size_clamped == '0) ? S_FLUSH : S_FETCH;
        end
      end
      S_FETCH:   w_next_state = S_WAIT_RD;
      S_WAIT_RD: w_next_state = S_ISSUE;
      S_ISSUE: begin
        if (w_handshake) begin
          w_next_state = (w_idx_inc == r_size) ? S_FLUSH : S_FETCH;
        end
`ifdef MS_SCHED_WDT_EN
        else if (w_wdt_expired) begin
          w_next_state = S_ERR;
        end
`endif
      end
      S_FLUSH: w_next_state = S_DRAIN;
      S_DRAIN: begin
        if (i_enc_finish) begin
          w_next_state = S_DONE;
        end
`ifdef MS_SCHED_WDT_EN
        else if (w_wdt_expired) begin
          w_next_state = S_ERR;
        end
`endif
      end
      S_DONE: w_next_state = S_IDLE;
`ifdef MS_SCHED_WDT_EN
      S_ERR:  w_next_state = S_IDLE;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Symbol path: index, captured size and the holding register that keeps
  // o_enc_data stable for the whole ISSUE wait.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_size     <= '0;
      r_idx      <= '0;
      r_enc_data <= '0;
    end else begin
      if (w_start_acc) begin
        r_size <= w_size_clamped;
        r_idx  <= '0;
      end else if ((r_state == S_ISSUE) && w_handshake) begin
        r_idx <= w_idx_inc;
      end
      // The BRAM returns data the cycle after the FETCH read enable.
      if (r_state == S_WAIT_RD) begin
        r_enc_data <= i_sym_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte capture: bytes are accepted in every state of an active job; once
  // the output BRAM is full they are dropped and the overflow flag sticks.
  // --------------------------------------------------------------------------
  assign w_capture_en = (r_state != S_IDLE) && !w_in_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte_cnt <= '0;
      r_overflow <= 1'b0;
      r_out_we   <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_out_we <= 1'b0;
      if (w_start_acc) begin
        r_byte_cnt <= '0;
        r_overflow <= 1'b0;
      end else if (w_capture_en && i_byte_vld) begin
        if (r_byte_cnt == c_out_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_out_we   <= 1'b1;
          r_out_addr <= r_byte_cnt[OUT_AW-1:0];
          r_out_data <= i_byte;
          r_byte_cnt <= r_byte_cnt + c_cnt_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_busy      = (r_state != S_IDLE) && !w_in_err;
  assign o_done      = (r_state == S_DONE) || w_in_err;
  assign o_sym_re    = (r_state == S_FETCH);
  assign o_sym_addr  = r_idx[SYM_AW-1:0];
  assign o_enc_valid = (r_state == S_ISSUE);
  assign o_enc_data  = r_enc_data;
  assign o_enc_flush = (r_state == S_FLUSH);
  assign o_byte_cnt  = r_byte_cnt;
  assign o_overflow  = r_overflow;
  assign o_out_we    = r_out_we;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_ms_enc_sched.sv
`default_nettype none
module tb_ms_enc_sched;

  localparam int SYM_AW = 4;
  localparam int OUT_AW = 2;
  localparam int WDT    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       size;
  logic              busy, done, overflow;
  logic [OUT_AW:0]   byte_cnt;
  logic              sym_re;
  logic [SYM_AW-1:0] sym_addr;
  logic [7:0]        sym_data;
  logic              enc_valid, enc_ready, enc_flush;
  logic [7:0]        enc_data;
  logic              byte_vld, enc_finish;
  logic [7:0]        byte_in;
  logic              out_we;
  logic [OUT_AW-1:0] out_addr;
  logic [7:0]        out_data;
  logic              err;

  ms_enc_sched #(.SYM_AW(SYM_AW), .OUT_AW(OUT_AW), .WDT_CYCLES(WDT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_size(size),
    .o_busy(busy), .o_done(done), .o_byte_cnt(byte_cnt), .o_overflow(overflow),
    .o_sym_re(sym_re), .o_sym_addr(sym_addr), .i_sym_data(sym_data),
    .o_enc_valid(enc_valid), .o_enc_data(enc_data), .i_enc_ready(enc_ready),
    .o_enc_flush(enc_flush), .i_byte_vld(byte_vld), .i_byte(byte_in),
    .i_enc_finish(enc_finish), .o_out_we(out_we), .o_out_addr(out_addr),
    .o_out_data(out_data), .o_err(err)
  );

  always #5 clk = ~clk;

  // Symbol BRAM model, one cycle read latency.
  logic [7:0] sym_mem [16];
  initial sym_data = 8'h00;
  always @(posedge clk) if (sym_re) sym_data <= sym_mem[sym_addr];

  int n_vec = 0;
  int n_err = 0;

  // Observation log, filled by tick().
  int                n_done, n_flush;
  logic [7:0]        acc[$];
  logic [SYM_AW-1:0] re_addr[$];
  logic [OUT_AW-1:0] wr_addr[$];
  logic [7:0]        wr_data[$];
  logic [7:0]        emit[$];

  task automatic clear_log();
    n_done = 0; n_flush = 0;
    acc.delete(); re_addr.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  // Advance one cycle; a transfer is the valid/ready pair present just before
  // the edge, everything else is sampled 1 time unit after the edge.
  task automatic tick();
    if (enc_valid && enc_ready) acc.push_back(enc_data);
    @(posedge clk);
    #1;
    if (done) n_done++;
    if (enc_flush) n_flush++;
    if (sym_re) re_addr.push_back(sym_addr);
    if (out_we) begin
      wr_addr.push_back(out_addr);
      wr_data.push_back(out_data);
    end
  endtask

  task automatic start_job(input logic [31:0] sz);
    clear_log();
    start = 1'b1; size = sz;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_flush(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (n_flush != 0) begin ok = 1'b1; break; end
      tick();
    end
    if (n_flush != 0) ok = 1'b1;
  endtask

  // Called in the FLUSH cycle: move to DRAIN, emit the queued bytes (the last
  // one together with i_enc_finish), then let the job wind down.
  task automatic finish_job();
    tick();
    if (emit.size() == 0) begin
      enc_finish = 1'b1;
      tick();
    end else begin
      for (int k = 0; k < emit.size(); k++) begin
        byte_vld = 1'b1; byte_in = emit[k];
        enc_finish = (k == emit.size() - 1);
        tick();
      end
    end
    byte_vld = 1'b0; enc_finish = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, byte_cnt, overflow, sym_re, sym_addr, enc_valid, enc_data,
         enc_flush, out_we, out_addr, out_data, err} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d re=%b valid=%b err=%b, expected all 0",
                        busy, done, byte_cnt, sym_re, enc_valid, err);
    end
    rst = 1'b0;
    clear_log();
    tick(); tick();
    n_vec++;
    if (busy !== 1'b0 || sym_re !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got busy=%b re=%b, expected 0 0", busy, sym_re);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] exp_sym [4];
    exp_sym = '{8'd3, 8'd7, 8'd0, 8'd255};
    for (int i = 0; i < 4; i++) sym_mem[i] = exp_sym[i];
    enc_ready = 1'b1;
    start_job(32'd4);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_flush(60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_flush_seen: got 0 expected 1"); end
    emit = '{8'hAA, 8'hBB};
    finish_job();
    n_vec++;
    if (acc.size() !== 4) begin n_err++; $display("FAIL basic_sym_count: got %0d expected 4", acc.size()); end
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      n_vec++;
      if (acc[i] !== exp_sym[i]) begin
        n_err++; $display("FAIL basic_sym%0d: got %0d expected %0d", i, acc[i], exp_sym[i]);
      end
    end
    n_vec++;
    if (re_addr.size() !== 4 || re_addr[3] !== 4'd3) begin
      n_err++; $display("FAIL basic_fetches: got %0d reads expected 4 ending at addr 3", re_addr.size());
    end
    n_vec++;
    if (n_flush !== 1 || n_done !== 1) begin
      n_err++; $display("FAIL basic_flush_done: got flush=%0d done=%0d expected 1 1", n_flush, n_done);
    end
    n_vec++;
    if (byte_cnt !== 3'd2 || wr_addr.size() !== 2) begin
      n_err++; $display("FAIL basic_bytes: got cnt=%0d writes=%0d expected 2 2", byte_cnt, wr_addr.size());
    end else begin
      n_vec++;
      if (wr_addr[0] !== 2'd0 || wr_data[0] !== 8'hAA || wr_addr[1] !== 2'd1 || wr_data[1] !== 8'hBB) begin
        n_err++; $display("FAIL basic_writes: got %0d:%h %0d:%h expected 0:aa 1:bb",
                          wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_size0();
    enc_ready = 1'b1;
    start_job(32'd0);
    n_vec++;
    if (enc_flush !== 1'b1) begin n_err++; $display("FAIL size0_flush_timing: got %b expected 1", enc_flush); end
    emit.delete();
    finish_job();
    n_vec++;
    if (re_addr.size() !== 0) begin n_err++; $display("FAIL size0_no_fetch: got %0d reads expected 0", re_addr.size()); end
    n_vec++;
    if (n_flush !== 1 || n_done !== 1 || byte_cnt !== 3'd0) begin
      n_err++; $display("FAIL size0_end: got flush=%0d done=%0d cnt=%0d expected 1 1 0", n_flush, n_done, byte_cnt);
    end
    // A byte presented while idle must be ignored.
    byte_vld = 1'b1; byte_in = 8'h55;
    tick();
    byte_vld = 1'b0;
    tick();
    n_vec++;
    if (wr_addr.size() !== 0 || byte_cnt !== 3'd0) begin
      n_err++; $display("FAIL idle_byte_ignored: got writes=%0d cnt=%0d expected 0 0", wr_addr.size(), byte_cnt);
    end
  endtask

  task automatic test_stall();
    int stall = 0;
    sym_mem[0] = 8'd10; sym_mem[1] = 8'd20; sym_mem[2] = 8'd30; sym_mem[3] = 8'd40;
    enc_ready = 1'b1;
    start_job(32'd4);
    for (int i = 0; i < 80 && n_flush == 0; i++) begin
      if (enc_valid && acc.size() == 2 && stall < 5) begin
        enc_ready = 1'b0;
        stall++;
        n_vec++;
        if (enc_data !== 8'd30) begin
          n_err++; $display("FAIL stall_data_hold: got %0d expected 30", enc_data);
        end
      end else begin
        enc_ready = 1'b1;
      end
      tick();
    end
    enc_ready = 1'b1;
    n_vec++;
    if (stall !== 5 || n_flush !== 1) begin
      n_err++; $display("FAIL stall_progress: got stall=%0d flush=%0d expected 5 1", stall, n_flush);
    end
    emit.delete();
    finish_job();
    n_vec++;
    if (re_addr.size() !== 4 || acc.size() !== 4) begin
      n_err++; $display("FAIL stall_no_extra_fetch: got reads=%0d syms=%0d expected 4 4", re_addr.size(), acc.size());
    end else begin
      n_vec++;
      if (acc[2] !== 8'd30 || acc[3] !== 8'd40) begin
        n_err++; $display("FAIL stall_order: got %0d %0d expected 30 40", acc[2], acc[3]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    sym_mem[0] = 8'd1;
    enc_ready = 1'b1;
    start_job(32'd1);
    wait_flush(30, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ovf_flush_seen: got 0 expected 1"); end
    emit = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    finish_job();
    n_vec++;
    if (wr_addr.size() !== 4 || byte_cnt !== 3'd4 || overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_count: got writes=%0d cnt=%0d ovf=%b expected 4 4 1",
                        wr_addr.size(), byte_cnt, overflow);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (wr_addr[k] !== 2'(k) || wr_data[k] !== 8'(11 * (k + 1))) begin
          n_err++; $display("FAIL ovf_write%0d: got %0d:%0d expected %0d:%0d", k, wr_addr[k], wr_data[k], k, 11 * (k + 1));
        end
      end
    end
    n_vec++;
    if (n_done !== 1) begin n_err++; $display("FAIL ovf_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_clamp();
    bit ok;
    for (int i = 0; i < 16; i++) sym_mem[i] = 8'(i * 13 + 5);
    enc_ready = 1'b1;
    start_job(32'd100);
    n_vec++;
    if (overflow !== 1'b0 || byte_cnt !== 3'd0) begin
      n_err++; $display("FAIL clamp_start_clears: got ovf=%b cnt=%0d expected 0 0", overflow, byte_cnt);
    end
    wait_flush(120, ok);
    emit.delete();
    finish_job();
    n_vec++;
    if (!ok || acc.size() !== 16 || re_addr.size() !== 16) begin
      n_err++; $display("FAIL clamp_count: got syms=%0d reads=%0d expected 16 16", acc.size(), re_addr.size());
    end else begin
      n_vec++;
      if (acc[0] !== 8'd5 || acc[15] !== 8'd200 || re_addr[15] !== 4'd15) begin
        n_err++; $display("FAIL clamp_data: got first=%0d last=%0d expected 5 200", acc[0], acc[15]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 4; i++) sym_mem[i] = 8'(90 + i);
    enc_ready = 1'b1;
    start_job(32'd4);
    for (int i = 0; i < 30 && acc.size() == 0; i++) tick();
    enc_ready = 1'b0;
    for (int i = 0; i < 10 && !enc_valid; i++) tick();
    n_vec++;
    if (enc_valid !== 1'b1 || sym_addr !== 4'd1) begin
      n_err++; $display("FAIL rstmid_setup: got valid=%b addr=%0d expected 1 1", enc_valid, sym_addr);
    end
    rst = 1'b1;
    #2;
    n_vec++;
    if ({busy, done, enc_valid, sym_addr, enc_data, enc_flush, byte_cnt, out_we} !== '0) begin
      n_err++; $display("FAIL rstmid_async: got busy=%b valid=%b addr=%0d data=%0d, expected all 0",
                        busy, enc_valid, sym_addr, enc_data);
    end
    rst = 1'b0;
    tick();
    enc_ready = 1'b1;
    start_job(32'd2);
    wait_flush(30, ok);
    emit.delete();
    finish_job();
    n_vec++;
    if (!ok || re_addr.size() !== 2 || re_addr[0] !== 4'd0) begin
      n_err++; $display("FAIL rstmid_restart_addr: got reads=%0d expected 2 starting at addr 0", re_addr.size());
    end else begin
      n_vec++;
      if (acc.size() !== 2 || acc[0] !== 8'd90 || acc[1] !== 8'd91 || n_done !== 1) begin
        n_err++; $display("FAIL rstmid_restart_job: got syms=%0d done=%0d expected 2 1", acc.size(), n_done);
      end
    end
  endtask

`ifdef MS_SCHED_WDT_EN
  task automatic test_wdt();
    int n = 0;
    sym_mem[0] = 8'd77;
    enc_ready = 1'b0;
    start_job(32'd1);
    for (int i = 0; i < 10 && !enc_valid; i++) tick();
    for (int i = 0; i < 40 && !done; i++) begin tick(); n++; end
    n_vec++;
    if (n !== WDT || err !== 1'b1 || busy !== 1'b0 || enc_valid !== 1'b0) begin
      n_err++; $display("FAIL wdt_fire: got cycles=%0d err=%b busy=%b valid=%b expected %0d 1 0 0",
                        n, err, busy, enc_valid, WDT);
    end
    tick(); tick();
    n_vec++;
    if (err !== 1'b1 || busy !== 1'b0 || n_done !== 1) begin
      n_err++; $display("FAIL wdt_sticky: got err=%b busy=%b done=%0d expected 1 0 1", err, busy, n_done);
    end
    enc_ready = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; size = '0; enc_ready = 1'b0;
    byte_vld = 1'b0; byte_in = '0; enc_finish = 1'b0;
    for (int i = 0; i < 16; i++) sym_mem[i] = 8'h00;
    clear_log();
    test_reset();
    test_basic();
    test_size0();
    test_stall();
    test_overflow();
    test_clamp();
    test_reset_mid();
`ifdef MS_SCHED_WDT_EN
    test_wdt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
